// File: rtl/intr_ack_sequencer.sv
// 8259-style interrupt sequencer: IRR capture, fixed-priority resolution against ISR,
// two-pulse INTA handshake with vector output, and normal/specific/automatic EOI.
module intr_ack_sequencer #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init_done,
  input  logic [7:0] i_ir,
  input  logic [7:0] i_imr,
  input  logic [4:0] i_t_base,
  input  logic       i_aeoi,
  input  logic       i_inta_n,
  input  logic       i_eoi,
  input  logic       i_seoi,
  input  logic [2:0] i_seoi_lvl,
  output logic       o_int,
  output logic [7:0] o_vec,
  output logic       o_vec_oe,
  output logic [7:0] o_irr,
  output logic [7:0] o_isr
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] P1   = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] P2   = 3'd4;

  logic [2:0] r_state;
  logic [7:0] r_irr, r_isr, r_ir_q, r_vec;
  logic       r_inta_q, r_int, r_vec_oe, r_spur;
  logic [2:0] r_sel;

  logic       w_inta_fall, w_inta_rise, w_ack;
  logic [7:0] w_req, w_ack_set, w_eoi_clr, w_aeoi_clr, w_irr_in;
  logic [2:0] w_cand_lvl;
  logic       w_cand_any, w_blocked, w_cand_valid;

  assign w_inta_fall = r_inta_q & ~i_inta_n;
  assign w_inta_rise = ~r_inta_q & i_inta_n;

  // Fully nested: the lowest unmasked request is serviceable only if nothing at or above it is in service.
  always_comb begin
    w_req      = r_irr & ~i_imr;
    w_cand_any = 1'b0;
    w_cand_lvl = 3'd0;
    w_blocked  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) begin
        w_cand_any = 1'b1;
        w_cand_lvl = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (r_isr[i] && (3'(i) <= w_cand_lvl)) w_blocked = 1'b1;
    end
    w_cand_valid = w_cand_any & ~w_blocked;
  end

  assign w_ack      = (r_state == REQ) & w_inta_fall;
  assign w_ack_set  = (w_ack & w_cand_valid) ? (8'd1 << w_cand_lvl) : 8'd0;
  assign w_aeoi_clr = ((r_state == P2) & w_inta_rise & i_aeoi & ~r_spur) ? (8'd1 << r_sel) : 8'd0;
  assign w_eoi_clr  = i_seoi ? (8'd1 << i_seoi_lvl) :
                      i_eoi  ? (r_isr & (~r_isr + 8'd1)) : 8'd0;
  assign w_irr_in   = LEVEL_MODE ? i_ir : (r_irr | (i_ir & ~r_ir_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_irr    <= 8'd0;
      r_isr    <= 8'd0;
      r_ir_q   <= 8'hFF;
      r_inta_q <= 1'b1;
      r_int    <= 1'b0;
      r_vec    <= 8'd0;
      r_vec_oe <= 1'b0;
      r_sel    <= 3'd0;
      r_spur   <= 1'b0;
    end else begin
      r_ir_q   <= i_ir;
      r_inta_q <= i_inta_n;
      if (!i_init_done) begin
        r_state  <= IDLE;
        r_int    <= 1'b0;
        r_vec_oe <= 1'b0;
        r_irr    <= 8'd0;
        r_isr    <= 8'd0;
      end else begin
        // Acknowledge clear beats a same-cycle set; newly set ISR bit survives any EOI.
        r_irr <= w_irr_in & ~w_ack_set;
        r_isr <= (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;
        case (r_state)
          IDLE: if (w_cand_valid) begin
            r_state <= REQ;
            r_int   <= 1'b1;
          end
          REQ: if (w_inta_fall) begin
            r_sel   <= w_cand_valid ? w_cand_lvl : 3'd7;
            r_spur  <= ~w_cand_valid;
            r_int   <= 1'b0;
            r_state <= P1;
          end
          P1: if (w_inta_rise) r_state <= GAP;
          GAP: if (w_inta_fall) begin
            r_vec    <= {i_t_base, r_sel};
            r_vec_oe <= 1'b1;
            r_state  <= P2;
          end
          P2: if (w_inta_rise) begin
            r_vec_oe <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_int    = r_int;
  assign o_vec    = r_vec;
  assign o_vec_oe = r_vec_oe;
  assign o_irr    = r_irr;
  assign o_isr    = r_isr;

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// Directed bench for intr_ack_sequencer; vectors are scoreboarded and checked by a monitor on vec_oe.
module tb_intr_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst, initDone, aeoi, intaN, eoi, seoi;
  logic [7:0] ir, imr;
  logic [4:0] tBase;
  logic [2:0] seoiLvl;

  logic       eInt, eVecOe, lInt, lVecOe;
  logic [7:0] eVec, eIrr, eIsr, lVec, lIrr, lIsr;

  logic       mode = 1'b0;
  logic       sInt, sVecOe;
  logic [7:0] sVec, sIrr, sIsr;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  intr_ack_sequencer #(.LEVEL_MODE(1'b0)) dutEdge (
    .i_clk(clk), .i_rst(rst), .i_init_done(initDone), .i_ir(ir), .i_imr(imr),
    .i_t_base(tBase), .i_aeoi(aeoi), .i_inta_n(intaN), .i_eoi(eoi), .i_seoi(seoi),
    .i_seoi_lvl(seoiLvl), .o_int(eInt), .o_vec(eVec), .o_vec_oe(eVecOe),
    .o_irr(eIrr), .o_isr(eIsr));

  intr_ack_sequencer #(.LEVEL_MODE(1'b1)) dutLevel (
    .i_clk(clk), .i_rst(rst), .i_init_done(initDone), .i_ir(ir), .i_imr(imr),
    .i_t_base(tBase), .i_aeoi(aeoi), .i_inta_n(intaN), .i_eoi(eoi), .i_seoi(seoi),
    .i_seoi_lvl(seoiLvl), .o_int(lInt), .o_vec(lVec), .o_vec_oe(lVecOe),
    .o_irr(lIrr), .o_isr(lIsr));

  assign sInt   = mode ? lInt   : eInt;
  assign sVec   = mode ? lVec   : eVec;
  assign sVecOe = mode ? lVecOe : eVecOe;
  assign sIrr   = mode ? lIrr   : eIrr;
  assign sIsr   = mode ? lIsr   : eIsr;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] irVal, input int n);
    ir = irVal;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic applyReset();
    rst = 1'b1; initDone = 1'b1; ir = 8'd0; imr = 8'd0; tBase = 5'b01000;
    aeoi = 1'b0; intaN = 1'b1; eoi = 1'b0; seoi = 1'b0; seoiLvl = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic pulseEoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic pulseOne();
    intaN = 1'b0; tick();
    checkOutput("int_low_after_p1", sInt, 8'd0);
    intaN = 1'b1; tick();
  endtask

  task automatic pulseTwo(input logic [7:0] expVec);
    expQ.push_back(expVec);
    intaN = 1'b0; tick();
    checkOutput("vec_oe_p2", sVecOe, 8'd1);
    intaN = 1'b1; tick();
    checkOutput("vec_oe_drop", sVecOe, 8'd0);
  endtask

  // Monitor: every rising vec_oe must match the next scoreboarded vector.
  initial begin
    logic prevOe;
    logic [7:0] e;
    prevOe = 1'b0;
    forever begin
      @(negedge clk);
      if (sVecOe && !prevOe) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL vec_unexpected actual=%h expected=none", sVec);
        end else begin
          e = expQ.pop_front();
          checkOutput("vec", sVec, e);
        end
      end
      prevOe = sVecOe;
    end
  end

  initial begin
    // Edge basic
    applyReset();
    checkOutput("reset_int", sInt, 8'd0);
    checkOutput("reset_isr", sIsr, 8'd0);
    checkOutput("reset_irr", sIrr, 8'd0);
    applyStimulus(8'h08, 1);
    checkOutput("edge_irr_set", sIrr, 8'h08);
    checkOutput("edge_int_not_yet", sInt, 8'd0);
    tick();
    checkOutput("edge_int_high", sInt, 8'd1);
    pulseOne();
    checkOutput("edge_isr", sIsr, 8'h08);
    checkOutput("edge_irr_clr", sIrr, 8'h00);
    pulseTwo(8'h43);
    pulseEoi();
    checkOutput("edge_eoi", sIsr, 8'h00);

    // Priority / nesting
    applyReset();
    applyStimulus(8'h20, 2);
    checkOutput("nest_int5", sInt, 8'd1);
    pulseOne();
    pulseTwo(8'h45);
    checkOutput("nest_isr20", sIsr, 8'h20);
    applyStimulus(8'h24, 2);
    checkOutput("nest_int2", sInt, 8'd1);
    pulseOne();
    checkOutput("nest_isr24", sIsr, 8'h24);
    pulseTwo(8'h42);
    applyStimulus(8'h64, 2);
    checkOutput("nest_irr6", sIrr, 8'h40);
    checkOutput("nest_int6_blocked", sInt, 8'd0);
    pulseEoi();
    checkOutput("nest_eoi1", sIsr, 8'h20);
    tick();
    checkOutput("nest_int6_still_blocked", sInt, 8'd0);
    pulseEoi();
    checkOutput("nest_eoi2", sIsr, 8'h00);
    tick();
    checkOutput("nest_int6_raised", sInt, 8'd1);
    pulseOne();
    pulseTwo(8'h46);

    // Mask before acknowledge gives spurious IR7
    applyReset();
    applyStimulus(8'h10, 2);
    checkOutput("mask_int", sInt, 8'd1);
    imr = 8'h10; tick();
    checkOutput("mask_int_held", sInt, 8'd1);
    pulseOne();
    checkOutput("mask_isr", sIsr, 8'h00);
    checkOutput("mask_irr", sIrr, 8'h10);
    pulseTwo(8'h47);
    tick();
    checkOutput("mask_no_int", sInt, 8'd0);

    // AEOI and specific EOI
    applyReset();
    aeoi = 1'b1;
    applyStimulus(8'h02, 2);
    pulseOne();
    checkOutput("aeoi_isr_set", sIsr, 8'h02);
    pulseTwo(8'h41);
    checkOutput("aeoi_isr_clr", sIsr, 8'h00);
    aeoi = 1'b0;
    applyStimulus(8'h00, 1);
    applyStimulus(8'h10, 2);
    pulseOne();
    pulseTwo(8'h44);
    applyStimulus(8'h12, 2);
    checkOutput("seoi_int1", sInt, 8'd1);
    pulseOne();
    pulseTwo(8'h41);
    checkOutput("seoi_isr12", sIsr, 8'h12);
    seoi = 1'b1; seoiLvl = 3'd4; eoi = 1'b1; tick();
    seoi = 1'b0; eoi = 1'b0;
    checkOutput("seoi_wins", sIsr, 8'h02);

    // Level mode
    mode = 1'b1;
    applyReset();
    applyStimulus(8'h01, 1);
    applyStimulus(8'h00, 1);
    checkOutput("lvl_int", sInt, 8'd1);
    checkOutput("lvl_irr_drop", sIrr, 8'h00);
    pulseOne();
    checkOutput("lvl_spur_isr", sIsr, 8'h00);
    pulseTwo(8'h47);
    applyStimulus(8'h01, 2);
    checkOutput("lvl_hold_int", sInt, 8'd1);
    pulseOne();
    checkOutput("lvl_hold_isr", sIsr, 8'h01);
    pulseTwo(8'h40);
    checkOutput("lvl_blocked", sInt, 8'd0);
    pulseEoi();
    checkOutput("lvl_eoi", sIsr, 8'h00);
    tick();
    checkOutput("lvl_rerequest", sInt, 8'd1);

    // Reset and reinit during GAP
    mode = 1'b0;
    applyReset();
    applyStimulus(8'h08, 2);
    pulseOne();
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("rst_gap_int", sInt, 8'd0);
    checkOutput("rst_gap_isr", sIsr, 8'h00);
    checkOutput("rst_gap_irr", sIrr, 8'h00);
    checkOutput("rst_gap_oe", sVecOe, 8'd0);
    intaN = 1'b0; tick(); intaN = 1'b1; tick();
    checkOutput("rst_inta_isr", sIsr, 8'h00);
    checkOutput("rst_inta_int", sInt, 8'd0);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h08, 2);
    pulseOne();
    initDone = 1'b0; tick(); initDone = 1'b1;
    checkOutput("init_gap_int", sInt, 8'd0);
    checkOutput("init_gap_isr", sIsr, 8'h00);
    checkOutput("init_gap_irr", sIrr, 8'h00);
    intaN = 1'b0; tick(); intaN = 1'b1; tick();
    checkOutput("init_inta_oe", sVecOe, 8'd0);
    checkOutput("init_inta_isr", sIsr, 8'h00);

    tick(); tick();
    checkOutput("scoreboard_empty", 8'(expQ.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ack_sequencer.md
# intr_ack_sequencer

Interrupt request, priority and acknowledge controller for the 8259-style PIC. It captures the eight IR lines into IRR and applies the IMR mask. It resolves fixed priority (IR0 highest) against the in-service register (ISR), drives INT, sequences the two-pulse INTA handshake and places the vector on the data path. It also retires in-service levels by normal EOI, specific EOI or automatic EOI (AEOI). It sits between the ICW/OCW read-write logic, which supplies configuration, and the bus data driver.

## Interface
- LEVEL_MODE, 0, 0 = edge-triggered IR capture, 1 = level-triggered (ICW1.LTIM fixed at build time)
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- init_done  in  1  ICW sequence complete; 0 = block held idle and cleared
- ir  in  8  interrupt request lines, already synchronous to clk
- imr  in  8  mask (OCW1), 1 = level masked
- t_base  in  5  vector bits 7:3 (ICW2)
- aeoi  in  1  automatic EOI enable (ICW4)
- inta_n  in  1  active-low interrupt acknowledge, synchronous to clk
- eoi  in  1  one-cycle pulse, non-specific EOI
- seoi  in  1  one-cycle pulse, specific EOI
- seoi_lvl  in  3  level cleared by seoi
- int  out  1  interrupt request to CPU
- vec  out  8  interrupt vector {t_base, level}
- vec_oe  out  1  vec valid / data-bus drive enable
- irr  out  8  interrupt request register
- isr  out  8  in-service register

## Operation
- Reset (rst=1 at a clock edge): irr=0, isr=0, int=0, vec=0, vec_oe=0, FSM=IDLE, ir_q=8'hFF, inta_q=1. A line high through reset does not create an edge.
- IRR, edge mode: irr[i] sets when ir[i]&~ir_q[i]. irr[i] stays set until acknowledged.
- IRR, level mode: irr[i] follows ir[i] while ir[i] is high and clears when ir[i] drops, except while bit i is being acknowledged.
- Candidate: the lowest index i with irr[i]&~imr[i]. It is valid only if no isr bit j<=i is set (fully nested).
- Ack-edge definitions: INTA falling = inta_q&~inta_n. INTA rising = ~inta_q&inta_n.
- FSM IDLE: init_done and a valid candidate → REQ, int<=1.
- FSM REQ: on INTA falling, re-evaluate the candidate and latch sel. If valid: isr[sel]<=1, irr[sel]<=0. If none: sel=7, spur=1, isr/irr unchanged. Then int<=0 → P1.
- FSM REQ, no acknowledge yet: int stays high even if the candidate vanishes (masked or level dropped). The acknowledge then yields a spurious IR7.
- FSM P1: on INTA rising → GAP.
- FSM GAP: on INTA falling → P2, vec<={t_base,sel}, vec_oe<=1.
- FSM P2: on INTA rising, vec_oe<=0. If aeoi and not spur, isr[sel]<=0. Then → IDLE.
- EOI: eoi clears the lowest-index set isr bit; no effect if isr=0. seoi clears isr[seoi_lvl].
- EOI, simultaneous pulses: eoi and seoi in the same cycle → seoi applied, eoi ignored.
- EOI during acknowledge: EOI in the same cycle as the REQ→P1 isr set is applied to the pre-set isr value. The newly set bit always survives.
- AEOI clear and an EOI in the same cycle are both applied (OR of clear masks).
- IRR set and acknowledge clear of the same bit in the same cycle → clear wins; the new edge is lost.
- init_done=0 at any time: next edge FSM=IDLE, int=0, vec_oe=0, irr=0, isr=0. ir_q and inta_q keep sampling.
- rst mid-handshake: full reset values. A pending INTA pulse is ignored until the next falling edge seen from IDLE→REQ.

## Timing
- All outputs are registered.
- ir rising sampled at edge N → irr bit set after N → int=1 after N+1 (two-cycle latency), if a valid candidate exists and init_done=1.
- inta_n first sampled low at edge M → int=0, isr/irr updated after M.
- Second pulse sampled low at edge K → vec/vec_oe valid after K. They stay valid while inta_n is low and drop one cycle after inta_n is sampled high.
- Each INTA low and high phase must be ≥1 cycle. Ack pulses arriving in IDLE are ignored.
- A higher-priority request arriving while the CPU is in service raises int again from IDLE. Lower or equal levels wait for EOI.
- Back-to-back service: the earliest next int is one cycle after the P2→IDLE transition.

## Test plan
- Edge basic: t_base=5'b01000, imr=0, ir[3] 0→1 → int high 2 cycles later. Two INTA pulses → isr=8'h08, irr=0, vec=8'h43 during pulse 2, int low after pulse 1.
- Priority/nesting: ir[5] acked (isr=8'h20), then ir[2] rises → int reasserts and ack gives vec low bits 2, isr=8'h24. ir[6] raised meanwhile stays in irr with no int until eoi twice (clears bit2, then bit5).
- Mask and spurious: ir[4] set, int high, imr=8'h10 applied before INTA → ack returns vec={t_base,3'd7}, isr unchanged=0.
- AEOI and specific EOI: aeoi=1, ack ir[1] → isr=0 after pulse 2. aeoi=0, isr=8'h12, seoi_lvl=4 with eoi in the same cycle → isr=8'h02.
- Level mode (LEVEL_MODE=1): ir[0] pulsed high 1 cycle then low before INTA → irr bit 0 clears, ack spurious. ir[0] held high → re-requests after eoi.
- Reset/reinit: rst or init_done=0 asserted during GAP → next cycle int=0, vec_oe=0, irr=isr=0. A subsequent INTA falling edge causes no state change.
